n64adv2_hdmi_clk_switch_seq: RTL and testbench
==============================================

Name: n64adv2_hdmi_clk_switch_seq

Overview:
- Sequencer on the system clock that owns changes of the HDMI pixel clock.
- When the requested HDMI clock selection or synthesizer configuration changes, it:
  - holds the HDMI domain in reset,
  - runs a four-phase request/acknowledge handshake with the clock-synthesizer configuration engine,
  - switches the glitch-free clock mux select,
  - waits a settle time, then releases the HDMI domain.
- It drives the hold and select inputs that the clock/reset housekeeping consumes.

Parameters:
- STABLE_CYCLES, 8: consecutive cycles a new request must stay unchanged before a sequence starts.
- GUARD_CYCLES, 16: wait after asserting hold, and again after switching the select.
- SETTLE_CYCLES, 1024: wait after the mux switch before releasing hold.
- CFG_TIMEOUT, 1048576: maximum cycles to wait for each handshake edge.

Ports:
- SYS_CLK_i  in  1  system clock; the only clock in this block.
- SYS_RST_i  in  1  synchronous reset, active-high.
- clk_sel_req_i  in  1  requested HDMI clock select (1 = sub clock, 0 = main clock).
- cfg_id_req_i  in  3  requested synthesizer configuration ID (target resolution code).
- cfg_ack_i  in  1  acknowledge from the configuration engine; already synchronous to SYS_CLK_i.
- cfg_req_o  out  1  configuration request.
- cfg_id_o  out  3  configuration ID; stable whenever cfg_req_o=1.
- clk_sel_o  out  1  clock mux select currently applied.
- hdmi_hold_o  out  1  forces the HDMI domain into reset while 1.
- busy_o  out  1  high in every state except IDLE.
- timeout_err_o  out  1  sticky handshake-timeout flag.

Behaviour:
- All outputs are registered. Reset is synchronous and active-high.
- Reset values while SYS_RST_i=1:
  - hdmi_hold_o=1, busy_o=1
  - clk_sel_o=0, cfg_id_o=0, cfg_req_o=0, timeout_err_o=0
  - state=START; all counters 0.
- START: on the first cycle after reset, latch tgt_sel/tgt_id from the inputs and go to HOLD. This guarantees an initial configuration.
- IDLE (hdmi_hold_o=0, busy_o=0):
  - A request is "different" when {clk_sel_req_i,cfg_id_req_i} != {clk_sel_o,cfg_id_o}.
  - A stability counter increments while the inputs are different and unchanged from the previous cycle. It clears on any input change or on equality.
  - When the count reaches STABLE_CYCLES, latch the target and go to HOLD. hdmi_hold_o rises on that same edge.
- HOLD: hdmi_hold_o=1. Count GUARD_CYCLES, then drive cfg_id_o=tgt_id, set cfg_req_o=1, and go to REQ.
- REQ: keep cfg_req_o=1 until cfg_ack_i=1.
  - On ack: cfg_req_o=0 on the next edge; go to ACK_LOW.
- ACK_LOW: wait for cfg_ack_i=0, then clk_sel_o<=tgt_sel and go to SWITCH.
- Handshake timeout: a single timeout counter restarts on entry to REQ and again on entry to ACK_LOW.
  - If it reaches CFG_TIMEOUT in REQ or ACK_LOW: timeout_err_o<=1, cfg_req_o<=0, clk_sel_o<=tgt_sel, go to SWITCH.
  - Hold is not released early on a timeout.
- SWITCH: count GUARD_CYCLES, then go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then hdmi_hold_o<=0 and go to IDLE.
- Input changes while busy_o=1 are ignored; the target is frozen at latch time. They are re-evaluated in IDLE, which starts a fresh STABLE_CYCLES count.
- clk_sel_o changes only on the ACK_LOW→SWITCH edge (or the timeout edge). hdmi_hold_o is always 1 at that edge.
- If tgt_sel equals the old clk_sel_o (ID-only change), the full sequence still runs.
- Counters saturate and never wrap. A counter "reaches N" on its Nth counted cycle.
- cfg_ack_i already high on entry to REQ counts as an immediate ack.
- timeout_err_o is cleared only by SYS_RST_i.
- SYS_RST_i mid-sequence: immediate return to the reset values (hold=1, req=0). The sequence then restarts through START.

Test Plan:
- Reset, inputs sel=1 id=3, ack responds after 5 cycles and falls 3 cycles later → cfg_req_o pulses with cfg_id_o=3; clk_sel_o=1 after ack falls; hdmi_hold_o falls exactly 16+1024 cycles after the select changes; busy_o=0.
- In IDLE, toggle cfg_id_req_i between 2 and 4 every 5 cycles for 100 cycles → no sequence starts. Hold id=4 steady → hdmi_hold_o rises after 8 stable cycles.
- Keep cfg_ack_i stuck at 0 → after CFG_TIMEOUT cycles in REQ: timeout_err_o=1, cfg_req_o=0, select applied, hold released after the settle time; timeout_err_o stays 1 through later sequences until reset.
- Change sel 0→1 during SETTLE → ignored until IDLE; a second full sequence then runs, and clk_sel_o changes only while hdmi_hold_o=1.
- Assert SYS_RST_i during REQ → next cycle: cfg_req_o=0, hdmi_hold_o=1, clk_sel_o=0, busy_o=1; a new sequence starts on release.
- ID-only change (sel unchanged, id 1→5) → full handshake; clk_sel_o constant; cfg_id_o=5.

Source files
------------

// File: rtl/n64adv2_hdmi_clk_switch_seq.sv
// rtl/n64adv2_hdmi_clk_switch_seq.sv - HDMI pixel clock change sequencer
// Holds the HDMI domain in reset around synthesizer reconfiguration and the mux switch.
module n64adv2_hdmi_clk_switch_seq #(
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned GUARD_CYCLES  = 16,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned CFG_TIMEOUT   = 1048576
) (
    input  logic       SYS_CLK_i,
    input  logic       SYS_RST_i,
    input  logic       clk_sel_req_i,
    input  logic [2:0] cfg_id_req_i,
    input  logic       cfg_ack_i,
    output logic       cfg_req_o,
    output logic [2:0] cfg_id_o,
    output logic       clk_sel_o,
    output logic       hdmi_hold_o,
    output logic       busy_o,
    output logic       timeout_err_o
);

    typedef enum logic [2:0] {
        ST_START,
        ST_IDLE,
        ST_HOLD,
        ST_REQ,
        ST_ACK_LOW,
        ST_SWITCH,
        ST_SETTLE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] stab_q, stab_d;
    logic [3:0]  req_prev_q, req_prev_d;
    logic [3:0]  tgt_q, tgt_d;
    logic        cfg_req_q, cfg_req_d;
    logic [2:0]  cfg_id_q, cfg_id_d;
    logic        clk_sel_q, clk_sel_d;
    logic        hold_q, hold_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [3:0]  req_now;
    logic [31:0] cnt_inc;
    logic [31:0] stab_inc;

    assign req_now  = {clk_sel_req_i, cfg_id_req_i};
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    assign stab_inc = (stab_q == '1) ? stab_q : stab_q + 32'd1;

    always_ff @(posedge SYS_CLK_i) begin
        if (SYS_RST_i) begin
            state_q    <= ST_START;
            cnt_q      <= '0;
            stab_q     <= '0;
            req_prev_q <= '0;
            tgt_q      <= '0;
            cfg_req_q  <= 1'b0;
            cfg_id_q   <= '0;
            clk_sel_q  <= 1'b0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stab_q     <= stab_d;
            req_prev_q <= req_prev_d;
            tgt_q      <= tgt_d;
            cfg_req_q  <= cfg_req_d;
            cfg_id_q   <= cfg_id_d;
            clk_sel_q  <= clk_sel_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stab_d     = '0;
        req_prev_d = req_now;
        tgt_d      = tgt_q;
        cfg_req_d  = cfg_req_q;
        cfg_id_d   = cfg_id_q;
        clk_sel_d  = clk_sel_q;
        err_d      = err_q;

        unique case (state_q)
            ST_START: begin
                tgt_d   = req_now;
                cnt_d   = '0;
                state_d = ST_HOLD;
            end
            ST_IDLE: begin
                // Requests that are new or still moving never accumulate stability.
                if ((req_now != {clk_sel_q, cfg_id_q}) && (req_now == req_prev_q)) begin
                    if (stab_q == STABLE_CYCLES - 1) begin
                        tgt_d   = req_now;
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        stab_d = stab_inc;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == GUARD_CYCLES - 1) begin
                    cfg_id_d  = tgt_q[2:0];
                    cfg_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REQ: begin
                if (cfg_ack_i) begin
                    cfg_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_ACK_LOW;
                end else if (cnt_q == CFG_TIMEOUT - 1) begin
                    err_d     = 1'b1;
                    cfg_req_d = 1'b0;
                    clk_sel_d = tgt_q[3];
                    cnt_d     = '0;
                    state_d   = ST_SWITCH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ACK_LOW: begin
                if (!cfg_ack_i || (cnt_q == CFG_TIMEOUT - 1)) begin
                    err_d     = err_q | cfg_ack_i;
                    clk_sel_d = tgt_q[3];
                    cnt_d     = '0;
                    state_d   = ST_SWITCH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SWITCH: begin
                if (cnt_q == GUARD_CYCLES - 1) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_CYCLES - 1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        // Hold and busy both track the next state so they change on the transition edge.
        hold_d = (state_d != ST_IDLE);
        busy_d = (state_d != ST_IDLE);
    end

    assign cfg_req_o     = cfg_req_q;
    assign cfg_id_o      = cfg_id_q;
    assign clk_sel_o     = clk_sel_q;
    assign hdmi_hold_o   = hold_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_n64adv2_hdmi_clk_switch_seq.sv
// tb/tb_n64adv2_hdmi_clk_switch_seq.sv - directed bench for the HDMI clock switch sequencer
// Timing is observed 1 ns after each rising edge; inputs change at the same point.
module tb_n64adv2_hdmi_clk_switch_seq;

    localparam int unsigned TO_CYC = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_req = 1'b1;
    logic [2:0] id_req = 3'd3;
    logic       ack = 1'b0;
    logic       cfg_req;
    logic [2:0] cfg_id;
    logic       clk_sel;
    logic       hold;
    logic       busy;
    logic       err;

    int errors = 0;
    int checks = 0;

    n64adv2_hdmi_clk_switch_seq #(
        .STABLE_CYCLES(8),
        .GUARD_CYCLES (16),
        .SETTLE_CYCLES(1024),
        .CFG_TIMEOUT  (TO_CYC)
    ) dut (
        .SYS_CLK_i    (clk),
        .SYS_RST_i    (rst),
        .clk_sel_req_i(sel_req),
        .cfg_id_req_i (id_req),
        .cfg_ack_i    (ack),
        .cfg_req_o    (cfg_req),
        .cfg_id_o     (cfg_id),
        .clk_sel_o    (clk_sel),
        .hdmi_hold_o  (hold),
        .busy_o       (busy),
        .timeout_err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input logic v, output int n);
        n = 0;
        while (cfg_req !== v && n < 5000) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_hold(input logic v, output int n);
        n = 0;
        while (hold !== v && n < 5000) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset;
        tick(3);
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL reset_hold got=%b exp=1", hold); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if ({cfg_req, cfg_id, clk_sel, err} !== 6'b0) begin
            errors++; $display("FAIL reset_outs got=%b exp=000000", {cfg_req, cfg_id, clk_sel, err});
        end
    endtask

    task automatic test_initial_config;
        int n;
        rst = 1'b0;
        wait_req(1'b1, n);
        checks++; if (n != 17) begin errors++; $display("FAIL init_req_latency got=%0d exp=17", n); end
        checks++; if (cfg_id !== 3'd3) begin errors++; $display("FAIL init_cfg_id got=%0d exp=3", cfg_id); end
        tick(5);
        ack = 1'b1;
        tick(1);
        checks++; if ({cfg_req, hold} !== 2'b01) begin errors++; $display("FAIL init_req_drop got=%b exp=01", {cfg_req, hold}); end
        tick(3);
        checks++; if (clk_sel !== 1'b0) begin errors++; $display("FAIL init_sel_early got=%b exp=0", clk_sel); end
        ack = 1'b0;
        tick(1);
        checks++; if (clk_sel !== 1'b1) begin errors++; $display("FAIL init_sel_switch got=%b exp=1", clk_sel); end
        wait_hold(1'b0, n);
        checks++; if (n != 1040) begin errors++; $display("FAIL init_settle got=%0d exp=1040", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy got=%b exp=0", busy); end
    endtask

    task automatic test_stability;
        int n;
        logic seen_busy;
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            id_req = (i % 2 == 0) ? 3'd4 : 3'd2;
            for (int k = 0; k < 5; k++) begin
                tick(1);
                if (busy !== 1'b0) seen_busy = 1'b1;
            end
        end
        checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL toggle_no_start got=%b exp=0", seen_busy); end
        id_req = 3'd4;
        wait_hold(1'b1, n);
        checks++; if (n != 9) begin errors++; $display("FAIL stable_start got=%0d exp=9", n); end
        wait_req(1'b1, n);
        checks++; if (n != 16 || cfg_id !== 3'd4) begin
            errors++; $display("FAIL stable_req got=%0d/%0d exp=16/4", n, cfg_id);
        end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        wait_hold(1'b0, n);
        checks++; if (n != 1041 || clk_sel !== 1'b1) begin
            errors++; $display("FAIL stable_done got=%0d/%b exp=1041/1", n, clk_sel);
        end
    endtask

    task automatic test_timeout;
        int n;
        sel_req = 1'b0;
        id_req  = 3'd6;
        wait_hold(1'b1, n);
        wait_req(1'b1, n);
        checks++; if (n != 16) begin errors++; $display("FAIL to_req got=%0d exp=16", n); end
        wait_req(1'b0, n);
        checks++; if (n != TO_CYC) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", n, TO_CYC); end
        checks++; if ({err, clk_sel, hold} !== 3'b101) begin
            errors++; $display("FAIL to_flags got=%b exp=101", {err, clk_sel, hold});
        end
        wait_hold(1'b0, n);
        checks++; if (n != 1040) begin errors++; $display("FAIL to_settle got=%0d exp=1040", n); end
    endtask

    task automatic test_busy_ignore;
        int n;
        logic bad;
        logic prev;
        id_req = 3'd2;
        wait_hold(1'b1, n);
        wait_req(1'b1, n);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(100);
        sel_req = 1'b1;
        bad = 1'b0;
        n = 0;
        while (hold === 1'b1 && n < 2000) begin
            tick(1);
            n++;
            if (clk_sel !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0 || hold !== 1'b0) begin
            errors++; $display("FAIL busy_ignore got=%b/%b exp=0/0", bad, hold);
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        wait_hold(1'b1, n);
        checks++; if (n != 8) begin errors++; $display("FAIL reeval_start got=%0d exp=8", n); end
        wait_req(1'b1, n);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        bad = 1'b0;
        n = 0;
        while (hold === 1'b1 && n < 2000) begin
            prev = clk_sel;
            tick(1);
            n++;
            if (clk_sel !== prev && hold !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0 || clk_sel !== 1'b1 || hold !== 1'b0) begin
            errors++; $display("FAIL second_seq got=%b/%b/%b exp=0/1/0", bad, clk_sel, hold);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        id_req = 3'd7;
        wait_hold(1'b1, n);
        wait_req(1'b1, n);
        rst = 1'b1;
        tick(1);
        checks++; if ({cfg_req, hold, clk_sel, busy, err} !== 5'b01010) begin
            errors++; $display("FAIL mid_reset got=%b exp=01010", {cfg_req, hold, clk_sel, busy, err});
        end
        rst = 1'b0;
        wait_req(1'b1, n);
        checks++; if (n != 17 || cfg_id !== 3'd7) begin
            errors++; $display("FAIL mid_restart got=%0d/%0d exp=17/7", n, cfg_id);
        end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        wait_hold(1'b0, n);
        checks++; if (clk_sel !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_done got=%b/%b exp=1/0", clk_sel, busy);
        end
    endtask

    task automatic test_id_only;
        int n;
        logic moved;
        id_req = 3'd5;
        wait_hold(1'b1, n);
        checks++; if (n != 9) begin errors++; $display("FAIL idonly_start got=%0d exp=9", n); end
        wait_req(1'b1, n);
        checks++; if (cfg_id !== 3'd5) begin errors++; $display("FAIL idonly_id got=%0d exp=5", cfg_id); end
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
        moved = 1'b0;
        n = 0;
        while (hold === 1'b1 && n < 2000) begin
            tick(1);
            n++;
            if (clk_sel !== 1'b1) moved = 1'b1;
        end
        checks++; if (moved !== 1'b0 || hold !== 1'b0 || cfg_id !== 3'd5) begin
            errors++; $display("FAIL idonly_done got=%b/%b/%0d exp=0/0/5", moved, hold, cfg_id);
        end
    endtask

    initial begin
        test_reset;
        test_initial_config;
        test_stability;
        test_timeout;
        test_busy_ignore;
        test_reset_mid;
        test_id_only;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
